// File: rtl/vga_ram_pkg.sv
// Shared types for the VGA/game RAM arbiter: grant encoding, sweep FSM states, default widths.
// The optional clear sweep is enabled with VGA_RAM_CLEAR_EN.
package vga_ram_pkg;

    localparam int DEF_DATA_WIDTH    = 8;
    localparam int DEF_ADDRESS_WIDTH = 8;
    localparam int DEF_DEPTH         = 256;
    localparam int DEF_MAX_WAIT      = 15;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_VGA  = 2'd1,
        GNT_GM   = 2'd2,
        GNT_CLR  = 2'd3
    } grant_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/vga_ram_arbiter_wait_counter.sv
// Saturating starvation counter: counts cycles a game request has waited, flags MAX_WAIT.
module arb_wait_counter #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic reset_n,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (inc && (cnt_reg != MAX_CNT)) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign sat = (cnt_reg == MAX_CNT);

endmodule

// File: rtl/vga_ram_arbiter.sv
// Single-port RAM arbiter: VGA fetcher has priority, game port gets a slot after MAX_WAIT cycles.
// Define VGA_RAM_CLEAR_EN to add the clear sweep (auto-runs after reset, restartable by clear_req).
module vga_ram_arbiter
    import vga_ram_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int DEPTH         = DEF_DEPTH,
    parameter int MAX_WAIT      = DEF_MAX_WAIT,
    parameter int CLEAR_VALUE   = 0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     vga_req,
    input  logic [ADDRESS_WIDTH-1:0] vga_addr,
    output logic                     vga_rvalid,
    output logic [DATA_WIDTH-1:0]    vga_rdata,
    output logic                     vga_miss,
    input  logic                     gm_valid,
    input  logic                     gm_we,
    input  logic [ADDRESS_WIDTH-1:0] gm_addr,
    input  logic [DATA_WIDTH-1:0]    gm_wdata,
    output logic                     gm_ready,
    output logic                     gm_rvalid,
    output logic [DATA_WIDTH-1:0]    gm_rdata,
    input  logic                     clear_req,
    output logic                     busy,
    output logic                     ram_wEn,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]    ram_dataIn,
    input  logic [DATA_WIDTH-1:0]    ram_dataOut
);

    grant_t                     grant;
    logic                       wait_sat;
    logic                       wait_inc;
    logic                       in_clear;
    logic [ADDRESS_WIDTH-1:0]   clr_addr;

    logic                       vga_rvalid_reg;
    logic                       vga_miss_reg;
    logic                       gm_rvalid_reg;
    logic [DATA_WIDTH-1:0]      vga_rdata_reg;
    logic [DATA_WIDTH-1:0]      gm_rdata_reg;

    // A starved game request outranks everything, including a VGA read to the same address.
    always_comb begin
        grant = GNT_NONE;
        if (gm_valid && wait_sat) begin
            grant = GNT_GM;
        end else if (vga_req) begin
            grant = GNT_VGA;
        end else if (in_clear) begin
            grant = GNT_CLR;
        end else if (gm_valid) begin
            grant = GNT_GM;
        end
    end

    always_comb begin
        ram_wEn    = 1'b0;
        ram_addr   = '0;
        ram_dataIn = '0;
        case (grant)
            GNT_VGA: begin
                ram_addr = vga_addr;
            end
            GNT_GM: begin
                ram_wEn    = gm_we;
                ram_addr   = gm_addr;
                ram_dataIn = gm_wdata;
            end
            GNT_CLR: begin
                ram_wEn    = 1'b1;
                ram_addr   = clr_addr;
                ram_dataIn = DATA_WIDTH'(CLEAR_VALUE);
            end
            default: ;
        endcase
    end

    assign gm_ready = (grant == GNT_GM);
    assign wait_inc = gm_valid && !gm_ready;

    arb_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (wait_inc),
        .clr     (!wait_inc),
        .sat     (wait_sat)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vga_rvalid_reg <= 1'b0;
            vga_miss_reg   <= 1'b0;
            gm_rvalid_reg  <= 1'b0;
            vga_rdata_reg  <= '0;
            gm_rdata_reg   <= '0;
        end else begin
            vga_rvalid_reg <= (grant == GNT_VGA);
            vga_miss_reg   <= vga_req && (grant != GNT_VGA);
            gm_rvalid_reg  <= (grant == GNT_GM) && !gm_we;
            if (vga_rvalid_reg) begin
                vga_rdata_reg <= ram_dataOut;
            end
            if (gm_rvalid_reg) begin
                gm_rdata_reg <= ram_dataOut;
            end
        end
    end

    // RAM read data arrives the cycle after the grant; pass it through then and hold it afterwards.
    assign vga_rvalid = vga_rvalid_reg;
    assign vga_miss   = vga_miss_reg;
    assign gm_rvalid  = gm_rvalid_reg;
    assign vga_rdata  = vga_rvalid_reg ? ram_dataOut : vga_rdata_reg;
    assign gm_rdata   = gm_rvalid_reg  ? ram_dataOut : gm_rdata_reg;

`ifdef VGA_RAM_CLEAR_EN
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

    state_t                     state_reg;
    state_t                     state_next;
    logic [ADDRESS_WIDTH-1:0]   clr_addr_reg;
    logic [ADDRESS_WIDTH-1:0]   clr_addr_next;
    logic                       init_pending_reg;

    // init_pending_reg launches the sweep on the first cycle after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= ST_IDLE;
            clr_addr_reg     <= '0;
            init_pending_reg <= 1'b1;
        end else begin
            state_reg        <= state_next;
            clr_addr_reg     <= clr_addr_next;
            init_pending_reg <= 1'b0;
        end
    end

    always_comb begin
        state_next    = state_reg;
        clr_addr_next = clr_addr_reg;
        case (state_reg)
            ST_IDLE: begin
                if (clear_req || init_pending_reg) begin
                    state_next    = ST_CLEAR;
                    clr_addr_next = '0;
                end
            end
            ST_CLEAR: begin
                if (grant == GNT_CLR) begin
                    if (clr_addr_reg == LAST_ADDR) begin
                        state_next    = ST_IDLE;
                        clr_addr_next = '0;
                    end else begin
                        clr_addr_next = clr_addr_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next    = ST_IDLE;
                clr_addr_next = '0;
            end
        endcase
    end

    assign in_clear = (state_reg == ST_CLEAR);
    assign clr_addr = clr_addr_reg;
    assign busy     = in_clear;
`else
    logic unused_clear_req;

    assign unused_clear_req = clear_req;
    assign in_clear         = 1'b0;
    assign clr_addr         = '0;
    assign busy             = 1'b0;
`endif

endmodule
